vga_pixel_fetch: RTL
====================

# vga_pixel_fetch

Streams framebuffer words from the video port of the shared memory into a small prefetch FIFO and serialises them into RGB222 pixels aligned to the VGA timing generator. It replaces the combinational byte-select/blanking path between `mem` and the VGA pins. It sits downstream of the timing generator (consumes HS/VS/DA) and of the memory video read port (consumes word data). Underflows are detected and flagged.

## Interface
- `BASE`, `'h200`: byte address of framebuffer word 0.
- `WORDS`, `4800`: framebuffer length in 32-bit words (160x120 pixels / 4).
- `DEPTH`, `4`: FIFO depth in words (power of two, ≥2).
- `VGA_BITS`, `8`: DAC width per colour channel.

- `clk`  in  1  pixel clock (same clock as the timing generator).
- `reset`  in  1  asynchronous, active-low reset.
- `hs_in`, `vs_in`  in  1 each  syncs from timing generator, active-low.
- `da_in`  in  1  display-area flag from timing generator; one pixel consumed per cycle high.
- `mem_rd`  out  1  read strobe to memory video port.
- `mem_addr`  out  32  byte address of word read, word-aligned.
- `mem_rdata`  in  32  read data, valid exactly 1 cycle after `mem_rd`.
- `VGA_R`, `VGA_G`, `VGA_B`  out  VGA_BITS each  colour; pixel byte `[5:4]`/`[3:2]`/`[1:0]` in MSBs, zero-filled below.
- `VGA_HS`, `VGA_VS`, `VGA_DA`  out  1 each  syncs/display flag delayed to match colour.
- `underflow`  out  1  sticky: pixel demanded while FIFO empty in current frame.

## Operation
- States: IDLE → FETCH → DONE → (frame start) FETCH. Reset enters IDLE.
- Frame start = falling edge of `vs_in` (registered previous value 1, current 0). In any state: flush FIFO (count=0, rd/wr pointers 0), discard in-flight read result, word counter `wc`=0, byte index `bi`=0, clear `underflow`, go FETCH.
- FETCH: assert `mem_rd` with `mem_addr = BASE + 4*wc` when `count + inflight < DEPTH` and `wc < WORDS`; increment `wc`. `inflight` is 0 or 1. When `wc` reaches `WORDS` and no read in flight, go DONE. DONE issues no reads.
- Push: cycle after an issued read, `mem_rdata` written at wr pointer.
- Consume: each cycle `da_in`=1 with FIFO non-empty selects byte `bi` of head word (bi=0 → `[7:0]`, little-endian, first pixel); `bi` increments mod 4; head popped when `bi`=3.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Underflow: `da_in`=1 with FIFO empty → pixel output black, `bi` not advanced, `underflow` set until next frame start.
- `da_in`=0: colour forced 0, `bi` and FIFO untouched.
- Address arithmetic 32-bit; `wc` width `$clog2(WORDS+1)`; pointers wrap mod DEPTH.

## Timing
- Output pipeline 1 register: `VGA_HS/VS/DA` at cycle t+1 = `hs_in/vs_in/da_in` at t; colour at t+1 = byte selected at t.
- Read latency: `mem_rd` at t → data in FIFO, visible as head, at t+2 (written at edge ending t+1).
- Steady state sustains 1 word/4 cycles against 1 pixel/cycle; refill after frame start fills DEPTH words within DEPTH·2+1 cycles.
- Reset values: `VGA_R/G/B`=0, `VGA_DA`=0, `VGA_HS`=`VGA_VS`=1, `mem_rd`=0, `mem_addr`=BASE, `underflow`=0, state IDLE, FIFO empty.
- Reset mid-frame: outputs to reset values immediately; no reads issued until next `vs_in` falling edge after release.
- Frame start coinciding with a push: push discarded.

## Test plan
- Reset: hold `reset`=0, toggle inputs → all outputs at reset values, `mem_rd`=0; release, no `vs_in` edge → stays IDLE, no reads.
- Prefetch: `vs_in` 1→0, memory model returns word = address → first reads 0x200,0x204,0x208,0x20C; `mem_rd` deasserts with 4 words queued.
- Pixel order: word 0x00302010 at 0x200, `da_in` high 4 cycles → `VGA_R/G/B` sequence for bytes 0x10,0x20,0x30,0x00 one cycle delayed (0x10 → R=0x40,G=0x00,B=0x00).
- Full frame: WORDS=8 override, 32 DA cycles → exactly 8 reads, last addr 0x21C, state DONE, `underflow`=0.
- Underflow: `da_in` high continuously from frame start with memory stalled (no reads honoured via model delay) → black output, `underflow`=1, cleared at next `vs_in` falling edge.
- Mid-frame restart: second `vs_in` falling edge after 3 words consumed → FIFO flushed, next read addr 0x200, `bi`=0.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Prefetches framebuffer words from the memory video port into a small FIFO and
// serialises them into RGB222 pixels, one register behind the VGA timing inputs.
module vga_pixel_fetch #(
  parameter logic [31:0] BASE     = 32'h200,
  parameter int          WORDS    = 4800,
  parameter int          DEPTH    = 4,
  parameter int          VGA_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                da_in,
  output logic                mem_rd,
  output logic [31:0]         mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic [VGA_BITS-1:0] VGA_R,
  output logic [VGA_BITS-1:0] VGA_G,
  output logic [VGA_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_DA,
  output logic                underflow,
  output logic [1:0]          state_dbg
);

  localparam int WC_W  = $clog2(WORDS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [WC_W-1:0]  WORDS_C = WC_W'(WORDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // state_dbg encoding: 0 = IDLE, 1 = FETCH, 2 = DONE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              vs_prev;
  logic [31:0]       fifo [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              inflight;
  logic [WC_W-1:0]   wc;
  logic [1:0]        bi;

  logic              frame_start;
  logic              issue;
  logic              push;
  logic              take;
  logic              pop;
  logic [31:0]       head;
  logic [7:0]        pix;

  assign frame_start = vs_prev & ~vs_in;
  assign push        = inflight & ~frame_start;
  assign take        = da_in & (count != '0);
  assign pop         = take & (bi == 2'd3);
  assign head        = fifo[rd_ptr];
  assign state_dbg   = state;

  // Memory handshake: mem_rd is a one-cycle strobe with mem_addr valid in the
  // same cycle; mem_rdata is taken unconditionally on the following cycle, so
  // at most one read is outstanding and the FIFO always has room for it.
  assign mem_rd   = issue;
  assign mem_addr = BASE + (32'(wc) << 2);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: state_next = S_IDLE;
      S_FETCH: begin
        if (!frame_start && (count + CNT_W'(inflight)) < DEPTH_C && wc < WORDS_C)
          issue = 1'b1;
        if (wc == WORDS_C && !inflight)
          state_next = S_DONE;
      end
      S_DONE: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (frame_start)
      state_next = S_FETCH;
  end

  always_comb begin
    pix = 8'h00;
    case (bi)
      2'd0: pix = head[7:0];
      2'd1: pix = head[15:8];
      2'd2: pix = head[23:16];
      2'd3: pix = head[31:24];
      default: pix = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_prev   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inflight  <= 1'b0;
      wc        <= '0;
      bi        <= 2'd0;
      underflow <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      if (frame_start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        inflight  <= 1'b0;
        wc        <= '0;
        bi        <= 2'd0;
        underflow <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue)
          wc <= wc + WC_W'(1);
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (take)
          bi <= bi + 2'd1;
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (da_in && count == '0)
          underflow <= 1'b1;
      end
    end
  end

  // Colour carries the pixel's two-bit fields in the DAC MSBs; blanking and
  // underflow both produce black.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_DA <= 1'b0;
    end else begin
      VGA_HS <= hs_in;
      VGA_VS <= vs_in;
      VGA_DA <= da_in;
      if (take) begin
        VGA_R <= {pix[5:4], {(VGA_BITS-2){1'b0}}};
        VGA_G <= {pix[3:2], {(VGA_BITS-2){1'b0}}};
        VGA_B <= {pix[1:0], {(VGA_BITS-2){1'b0}}};
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule
